tcam_table_loader: RTL and testbench

Programming front-end for the TCAM-based adder datapath. It accepts table entries over a valid/ready write stream into a shadow bank. It commits them atomically to the active lookup tables, which drive the `data` (128×5) and `data_add` (8×2) inputs of every 8-bit/16-bit adder instance. The adders therefore never observe a partially written table.

---
 rtl/tcam_loader_pkg.sv | 27 ++
 rtl/tcam_shadow_bank.sv | 60 ++++++
 rtl/tcam_table_loader.sv | 176 +++++++++++++++++
 tb/tb_tcam_table_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_loader_pkg.sv
// Shared constants and types for the TCAM table loader.
package tcam_loader_pkg;

   localparam int TCAM_DATA_DEPTH = 128;
   localparam int TCAM_DATA_W     = 5;
   localparam int TCAM_ADD_DEPTH  = 8;
   localparam int TCAM_ADD_W      = 2;
   localparam int TCAM_ADDR_W     = 7;
   localparam int TCAM_BITMAP_W   = TCAM_DATA_DEPTH + TCAM_ADD_DEPTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } loader_state_t;

   typedef enum logic {
      MAIN = 1'b0,
      ADD  = 1'b1
   } tbl_sel_t;

   // The add table only has 8 entries; any upper address bit set is out of range.
   function automatic logic add_addr_ok(input logic [TCAM_ADDR_W-1:0] addr);
      return (addr[TCAM_ADDR_W-1:3] == '0);
   endfunction

endpackage

// File: rtl/tcam_shadow_bank.sv
// Shadow copy of both lookup tables plus the per-entry written bitmap.
// complete_o looks at the next-state bitmap so a write accepted in the same
// cycle as the commit request is counted.
module tcam_shadow_bank
   import tcam_loader_pkg::*;
#(
   parameter int DATA_DEPTH = TCAM_DATA_DEPTH,
   parameter int DATA_W     = TCAM_DATA_W,
   parameter int ADD_DEPTH  = TCAM_ADD_DEPTH,
   parameter int ADD_W      = TCAM_ADD_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr_i,
   input  logic                                 we_i,
   input  tbl_sel_t                             sel_i,
   input  logic [TCAM_ADDR_W-1:0]               addr_i,
   input  logic [DATA_W-1:0]                    data_i,
   output logic [DATA_DEPTH-1:0][DATA_W-1:0]    sh_data_o,
   output logic [ADD_DEPTH-1:0][ADD_W-1:0]      sh_add_o,
   output logic                                 complete_o
);

   localparam int BM_W  = DATA_DEPTH + ADD_DEPTH;
   localparam int BM_IW = $clog2(BM_W);
   localparam int AA_W  = $clog2(ADD_DEPTH);

   logic [DATA_DEPTH-1:0][DATA_W-1:0] sh_data_q;
   logic [ADD_DEPTH-1:0][ADD_W-1:0]   sh_add_q;
   logic [BM_W-1:0]                   bm_q, bm_d;
   logic [BM_IW-1:0]                  bm_idx;

   // Shadow storage: contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         if (sel_i == MAIN) sh_data_q[addr_i] <= data_i;
         else               sh_add_q[addr_i[AA_W-1:0]] <= data_i[ADD_W-1:0];
      end
   end

   // Next written bitmap: cleared on session (re)start, else mark the written entry.
   always_comb begin
      bm_d   = bm_q;
      bm_idx = (sel_i == MAIN) ? BM_IW'(addr_i)
                               : BM_IW'(DATA_DEPTH) + BM_IW'(addr_i[AA_W-1:0]);
      if (clr_i)     bm_d = '0;
      else if (we_i) bm_d[bm_idx] = 1'b1;
   end

   // Written bitmap register.
   always_ff @(posedge clk) begin
      if (rst) bm_q <= '0;
      else     bm_q <= bm_d;
   end

   assign sh_data_o  = sh_data_q;
   assign sh_add_o   = sh_add_q;
   assign complete_o = &bm_d;

endmodule

// File: rtl/tcam_table_loader.sv
// Programming front-end for the TCAM adder tables: collects entries into a
// shadow bank and commits them atomically to the active tables.
// Optional readback port: define TCAM_LOADER_READBACK_EN.
//
// state  | meaning
// IDLE   | no session; writes ignored
// LOAD   | accepting writes into shadow, wr_ready high
// COMMIT | one cycle copying shadow to active tables
module tcam_table_loader
   import tcam_loader_pkg::*;
#(
   parameter int DATA_DEPTH = TCAM_DATA_DEPTH,
   parameter int DATA_W     = TCAM_DATA_W,
   parameter int ADD_DEPTH  = TCAM_ADD_DEPTH,
   parameter int ADD_W      = TCAM_ADD_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load_start,
   input  logic                                 load_end,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic                                 wr_sel,
   input  logic [TCAM_ADDR_W-1:0]               wr_addr,
   input  logic [DATA_W-1:0]                    wr_data,
   output logic [DATA_DEPTH-1:0][DATA_W-1:0]    data,
   output logic [ADD_DEPTH-1:0][ADD_W-1:0]      data_add,
   output logic                                 tables_valid,
   output logic                                 load_done,
   output logic                                 load_err,
   output logic                                 busy
`ifdef TCAM_LOADER_READBACK_EN
   ,
   input  logic                                 rd_en,
   input  logic                                 rd_sel,
   input  logic [TCAM_ADDR_W-1:0]               rd_addr,
   output logic [DATA_W-1:0]                    rd_data
`endif
);

   localparam int AA_W = $clog2(ADD_DEPTH);

   loader_state_t state_q, state_d;
   logic          wr_ready_q;
   logic          tables_valid_q;
   logic          load_done_q, load_done_d;
   logic          load_err_q, load_err_d;
   logic          err_q, err_d;

   logic [DATA_DEPTH-1:0][DATA_W-1:0] data_q;
   logic [ADD_DEPTH-1:0][ADD_W-1:0]   add_q;
   logic [DATA_DEPTH-1:0][DATA_W-1:0] sh_data;
   logic [ADD_DEPTH-1:0][ADD_W-1:0]   sh_add;

   tbl_sel_t sel;
   logic     accept, range_bad, we, clr, complete, commit_ok;

   // A restart in the same cycle as a write discards the write; the bitmap is cleared anyway.
   assign sel       = tbl_sel_t'(wr_sel);
   assign accept    = wr_valid && wr_ready_q && !load_start;
   assign range_bad = (sel == ADD) && !add_addr_ok(wr_addr);
   assign we        = accept && !range_bad;
   assign clr       = load_start && (state_q != COMMIT);

   tcam_shadow_bank #(
      .DATA_DEPTH (DATA_DEPTH),
      .DATA_W     (DATA_W),
      .ADD_DEPTH  (ADD_DEPTH),
      .ADD_W      (ADD_W)
   ) u_shadow (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .we_i       (we),
      .sel_i      (sel),
      .addr_i     (wr_addr),
      .data_i     (wr_data),
      .sh_data_o  (sh_data),
      .sh_add_o   (sh_add),
      .complete_o (complete)
   );

   // Sticky range error for the current session, including a same-cycle bad write.
   always_comb begin
      err_d = err_q;
      if (clr)                        err_d = 1'b0;
      else if (accept && range_bad)   err_d = 1'b1;
   end

   assign commit_ok = complete && !err_d;

   // Next-state and pulse decode.
   always_comb begin
      state_d     = state_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) state_d = LOAD;
         end
         LOAD: begin
            if (load_start) begin
               state_d = LOAD;
            end else if (load_end) begin
               if (commit_ok) begin
                  state_d = COMMIT;
               end else begin
                  state_d    = IDLE;
                  load_err_d = 1'b1;
               end
            end
         end
         COMMIT: begin
            state_d     = IDLE;
            load_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, handshake and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ready_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ready_q  <= (state_d == LOAD);
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         err_q       <= err_d;
      end
   end

   // Active tables change only here, so the adders never see a partial image.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q         <= '0;
         add_q          <= '0;
         tables_valid_q <= 1'b0;
      end else if (state_q == COMMIT) begin
         data_q         <= sh_data;
         add_q          <= sh_add;
         tables_valid_q <= 1'b1;
      end
   end

`ifdef TCAM_LOADER_READBACK_EN
   logic [DATA_W-1:0] rd_data_q;

   // Registered readback of the active tables; holds when rd_en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         if (!rd_sel)                 rd_data_q <= data_q[rd_addr];
         else if (add_addr_ok(rd_addr)) rd_data_q <= DATA_W'(add_q[rd_addr[AA_W-1:0]]);
         else                         rd_data_q <= '0;
      end
   end

   assign rd_data = rd_data_q;
`endif

   assign wr_ready     = wr_ready_q;
   assign data         = data_q;
   assign data_add     = add_q;
   assign tables_valid = tables_valid_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tcam_table_loader.sv
// Directed/randomized bench for tcam_table_loader with a table-level reference model.
module tb_tcam_table_loader;

   logic clk = 1'b0;
   logic rst, load_start, load_end, wr_valid, wr_sel;
   logic [6:0] wr_addr;
   logic [4:0] wr_data;
   logic wr_ready, tables_valid, load_done, load_err, busy;
   logic [127:0][4:0] data;
   logic [7:0][1:0]   data_add;
`ifdef TCAM_LOADER_READBACK_EN
   logic rd_en, rd_sel;
   logic [6:0] rd_addr;
   logic [4:0] rd_data;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // reference model: shadow image, written flags, session error, active image
   logic [4:0] m_sh  [128];
   logic [1:0] m_sha [8];
   bit         m_bm  [136];
   bit         m_err;
   logic [4:0] e_data [128];
   logic [1:0] e_add  [8];
   bit         e_valid;

   always #5 clk = ~clk;

   tcam_table_loader dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .load_end     (load_end),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_sel       (wr_sel),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .data         (data),
      .data_add     (data_add),
      .tables_valid (tables_valid),
      .load_done    (load_done),
      .load_err     (load_err),
      .busy         (busy)
`ifdef TCAM_LOADER_READBACK_EN
      ,
      .rd_en        (rd_en),
      .rd_sel       (rd_sel),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data)
`endif
   );

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [639:0] exp_data_vec();
      logic [639:0] v;
      for (int i = 0; i < 128; i++) v[i*5 +: 5] = e_data[i];
      return v;
   endfunction

   function automatic logic [15:0] exp_add_vec();
      logic [15:0] v;
      for (int i = 0; i < 8; i++) v[i*2 +: 2] = e_add[i];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_tables(input string tag);
      chk({tag, "_data"}, 640'(data), exp_data_vec());
      chk({tag, "_add"}, 640'(data_add), 640'(exp_add_vec()));
      chk({tag, "_valid"}, 640'(tables_valid), 640'(e_valid));
   endtask

   task automatic model_write(input bit sel, input logic [6:0] a, input logic [4:0] d);
      if (sel && a[6:3] != 4'd0) begin
         m_err = 1'b1;
      end else if (!sel) begin
         m_sh[a] = d;
         m_bm[a] = 1'b1;
      end else begin
         m_sha[a[2:0]]        = d[1:0];
         m_bm[128 + a[2:0]]   = 1'b1;
      end
   endtask

   // Called one time unit after the edge that sampled load_end.
   task automatic check_end(input string tag);
      bit ok;
      ok = !m_err;
      for (int i = 0; i < 136; i++) if (!m_bm[i]) ok = 1'b0;
      if (ok) begin
         chk({tag, "_commit_busy"}, 640'(busy), 640'(1));
         chk({tag, "_done_early"}, 640'(load_done), 640'(0));
         check_tables({tag, "_pre"});
         step();
         for (int i = 0; i < 128; i++) e_data[i] = m_sh[i];
         for (int i = 0; i < 8; i++)   e_add[i]  = m_sha[i];
         e_valid = 1'b1;
         chk({tag, "_done"}, 640'(load_done), 640'(1));
         chk({tag, "_idle"}, 640'(busy), 640'(0));
         check_tables({tag, "_post"});
         step();
         chk({tag, "_done_clr"}, 640'(load_done), 640'(0));
      end else begin
         chk({tag, "_err"}, 640'(load_err), 640'(1));
         chk({tag, "_err_idle"}, 640'(busy), 640'(0));
         chk({tag, "_err_ready"}, 640'(wr_ready), 640'(0));
         check_tables({tag, "_kept"});
         step();
         chk({tag, "_err_clr"}, 640'(load_err), 640'(0));
      end
   endtask

   task automatic wr(input bit sel, input logic [6:0] a, input logic [4:0] d, input bit with_end,
                     input string tag);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_addr  = a;
      wr_data  = d;
      load_end = with_end;
      model_write(sel, a, d);
      step();
      wr_valid = 1'b0;
      load_end = 1'b0;
      if (with_end) check_end(tag);
   endtask

   task automatic start(input string tag);
      load_start = 1'b1;
      for (int i = 0; i < 136; i++) m_bm[i] = 1'b0;
      m_err = 1'b0;
      step();
      load_start = 1'b0;
      chk({tag, "_ready"}, 640'(wr_ready), 640'(1));
      chk({tag, "_busy"}, 640'(busy), 640'(1));
   endtask

   task automatic end_load(input string tag);
      load_end = 1'b1;
      step();
      load_end = 1'b0;
      check_end(tag);
   endtask

   // Writes every entry except index `skip` (0..127 main, 128..135 add) in random order.
   task automatic write_all(input int skip, input bit rnd);
      int ord [136];
      for (int i = 0; i < 136; i++) ord[i] = i;
      for (int i = 135; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 136; i++) begin
         int k;
         k = ord[i];
         if (k == skip) continue;
         if (k < 128) wr(1'b0, 7'(k), rnd ? 5'($urandom) : 5'(k % 32), 1'b0, "wa");
         else         wr(1'b1, 7'(k - 128), rnd ? 5'($urandom) : 5'((k - 128) % 4), 1'b0, "wa");
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) e_data[i] = 5'd0;
      for (int i = 0; i < 8; i++)   e_add[i]  = 2'd0;
      e_valid = 1'b0;
      for (int i = 0; i < 136; i++) m_bm[i] = 1'b0;
      m_err = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; load_end = 1'b0; wr_valid = 1'b0;
      wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef TCAM_LOADER_READBACK_EN
      rd_en = 1'b0; rd_sel = 1'b0; rd_addr = '0;
`endif
      do_reset();
      chk("rst_busy", 640'(busy), 640'(0));
      chk("rst_ready", 640'(wr_ready), 640'(0));
      chk("rst_done", 640'(load_done), 640'(0));
      chk("rst_err", 640'(load_err), 640'(0));
      check_tables("rst");

      // load_end and writes in IDLE are ignored
      load_end = 1'b1; wr_valid = 1'b1; wr_addr = 7'd5; wr_data = 5'h1F;
      step();
      load_end = 1'b0; wr_valid = 1'b0;
      chk("idle_end_busy", 640'(busy), 640'(0));
      step();
      chk("idle_end_err", 640'(load_err), 640'(0));
      check_tables("idle_wr");

      // incomplete image: main entry 100 missing
      start("s_skip");
      write_all(100, 1'b0);
      end_load("skip100");

      // full image with the fixed pattern
      start("s_full");
      write_all(-1, 1'b0);
      end_load("full");
      chk("full_d37", 640'(data[37]), 640'(5));
      chk("full_a6", 640'(data_add[6]), 640'(2));

`ifdef TCAM_LOADER_READBACK_EN
      rd_en = 1'b1; rd_sel = 1'b0; rd_addr = 7'd37;
      step();
      chk("rb_main37", 640'(rd_data), 640'(5));
      rd_sel = 1'b1; rd_addr = 7'd12;
      step();
      chk("rb_add12", 640'(rd_data), 640'(0));
      rd_addr = 7'd6;
      step();
      chk("rb_add6", 640'(rd_data), 640'(2));
      rd_en = 1'b0; rd_addr = 7'd1;
      step();
      chk("rb_hold", 640'(rd_data), 640'(2));
`endif

      // out-of-range add write poisons the session even when the image is complete
      start("s_oor");
      wr(1'b1, 7'd9, 5'd3, 1'b0, "oor");
      write_all(-1, 1'b1);
      end_load("oor");

      // entry 3 written twice, last write lands with load_end
      start("s_dup");
      write_all(3, 1'b0);
      wr(1'b0, 7'd3, 5'h1A, 1'b0, "dup1");
      wr(1'b0, 7'd3, 5'h05, 1'b1, "dup2");
      chk("dup_d3", 640'(data[3]), 640'(5));

      // randomized sessions: partial session, restart, full random image, random rewrites
      for (int r = 0; r < 3; r++) begin
         start("s_rnd_a");
         for (int i = 0; i < 20; i++) wr(1'($urandom), 7'($urandom), 5'($urandom), 1'b0, "rp");
         start("s_rnd_b");
         write_all(-1, 1'b1);
         for (int i = 0; i < 10; i++) wr(1'b0, 7'($urandom), 5'($urandom), 1'b0, "rw");
         for (int i = 0; i < 4; i++)  wr(1'b1, 7'($urandom_range(7, 0)), 5'($urandom), 1'b0, "rwa");
         end_load("rnd");
      end

      // reset mid-load clears everything
      start("s_mid");
      for (int i = 0; i < 50; i++) wr(1'b0, 7'(i), 5'($urandom), 1'b0, "mid");
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) e_data[i] = 5'd0;
      for (int i = 0; i < 8; i++)   e_add[i]  = 2'd0;
      e_valid = 1'b0;
      chk("mid_busy", 640'(busy), 640'(0));
      chk("mid_ready", 640'(wr_ready), 640'(0));
      check_tables("mid");
      step();
      chk("mid_ready2", 640'(wr_ready), 640'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
